// File: rtl/prga_prog_receiver.sv
// Fabric-side serial programming endpoint: header/payload/CRC frame receiver.
// Payload bits feed the scan chain; the chain tail is echoed for readback.
module prga_prog_receiver #(
  parameter logic [7:0] MAGIC    = 8'hA5,
  parameter int         LEN_W    = 24,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic prog_clk,
  input  logic prog_rst_n,
  input  logic prog_we,
  input  logic prog_din,
  output logic chain_we,
  output logic chain_din,
  input  logic chain_dout,
  output logic prog_we_o,
  output logic prog_dout,
  output logic prog_done,
  output logic prog_err
);

  localparam int HW = 8 + LEN_W;
  localparam int CW = $clog2(HW);

  typedef enum logic [2:0] {
    HEADER,
    PAYLOAD,
    CRC,
    DONE,
    ERROR
  } state_t;

  state_t           state, state_n;
  logic [HW-2:0]    hdr;
  logic [HW-1:0]    hdr_n;
  logic [6:0]       trl;
  logic [7:0]       trl_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [CW-1:0]    bcnt, bcnt_n;
  logic [7:0]       crc, crc_n;
  logic             hdr_en, trl_en;
  logic             cwe_n, cdin_n;
  logic             fb;

  assign hdr_n = {hdr, prog_din};
  assign trl_n = {trl, prog_din};
  assign fb    = crc[7] ^ prog_din;

  assign prog_done = (state == DONE);
  assign prog_err  = (state == ERROR);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bcnt_n  = bcnt;
    crc_n   = crc;
    hdr_en  = 1'b0;
    trl_en  = 1'b0;
    cwe_n   = 1'b0;
    cdin_n  = chain_din;
    if (prog_we) begin
      case (state)
        HEADER: begin
          hdr_en = 1'b1;
          bcnt_n = bcnt + 1'b1;
          if (bcnt == CW'(HW - 1)) begin
            bcnt_n = '0;
            if (hdr_n[HW-1 -: 8] != MAGIC) begin
              state_n = ERROR;
            end else if (hdr_n[LEN_W-1:0] == '0) begin
              state_n = CRC;
            end else begin
              state_n = PAYLOAD;
              cnt_n   = hdr_n[LEN_W-1:0];
            end
          end
        end
        PAYLOAD: begin
          cwe_n  = 1'b1;
          cdin_n = prog_din;
          crc_n  = {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
          cnt_n  = cnt - 1'b1;
          if (cnt == LEN_W'(1)) begin
            state_n = CRC;
          end
        end
        CRC: begin
          trl_en = 1'b1;
          bcnt_n = bcnt + 1'b1;
          if (bcnt == CW'(7)) begin
            bcnt_n  = '0;
            state_n = (trl_n == crc) ? DONE : ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state     <= HEADER;
      hdr       <= '0;
      trl       <= '0;
      cnt       <= '0;
      bcnt      <= '0;
      crc       <= '0;
      chain_we  <= 1'b0;
      chain_din <= 1'b0;
      prog_we_o <= 1'b0;
      prog_dout <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bcnt      <= bcnt_n;
      crc       <= crc_n;
      chain_we  <= cwe_n;
      chain_din <= cdin_n;
      prog_we_o <= chain_we;
      prog_dout <= chain_we & chain_dout;
      if (hdr_en) hdr <= hdr_n[HW-2:0];
      if (trl_en) trl <= trl_n[6:0];
    end
  end

endmodule

// File: tb/tb_prga_prog_receiver.sv
// Bench for prga_prog_receiver: table vectors, random frames, corner sequences.
// Chain is a 16-bit shift register preloaded with 16'hBEEF.
module tb_prga_prog_receiver;

  logic prog_clk = 1'b0;
  logic prog_rst_n;
  logic prog_we;
  logic prog_din;
  logic chain_we;
  logic chain_din;
  logic chain_dout;
  logic prog_we_o;
  logic prog_dout;
  logic prog_done;
  logic prog_err;

  logic [15:0] chain;
  logic        preload;

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) begin
    if (preload) chain <= 16'hBEEF;
    else if (chain_we) chain <= {chain[14:0], chain_din};
  end
  assign chain_dout = chain[15];

  prga_prog_receiver dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .prog_we    (prog_we),
    .prog_din   (prog_din),
    .chain_we   (chain_we),
    .chain_din  (chain_din),
    .chain_dout (chain_dout),
    .prog_we_o  (prog_we_o),
    .prog_dout  (prog_dout),
    .prog_done  (prog_done),
    .prog_err   (prog_err)
  );

  typedef struct {
    logic [7:0]  magic;
    int unsigned len;
    logic [63:0] pay;
    int          trl;
    int          gap;
    int          exp_done;
    int          exp_err;
    int          exp_pulses;
  } vec_t;

  int total = 0;
  int bad   = 0;
  bit q_cw[$];
  bit q_rb[$];
  int ncyc = 0;
  int first_cw, last_cw;
  logic s_done, s_err;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference CRC by polynomial long division of M(x)*x^8 by 0x107.
  function automatic logic [7:0] ref_crc(input bit b[$]);
    bit m[$];
    logic [8:0] p;
    logic [7:0] r;
    p = 9'h107;
    m = b;
    for (int i = 0; i < 8; i++) m.push_back(1'b0);
    for (int i = 0; i + 8 < m.size(); i++) begin
      if (m[i]) begin
        for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ p[8-j];
      end
    end
    for (int j = 0; j < 8; j++) r[7-j] = m[m.size()-8+j];
    return r;
  endfunction

  task automatic tick(input bit we, input bit din);
    @(negedge prog_clk);
    if (chain_we) begin
      q_cw.push_back(chain_din);
      if (first_cw < 0) first_cw = ncyc;
      last_cw = ncyc;
    end
    if (prog_we_o) q_rb.push_back(prog_dout);
    s_done = prog_done;
    s_err  = prog_err;
    ncyc++;
    prog_we  = we;
    prog_din = din;
  endtask

  task automatic do_reset(input string tag);
    @(negedge prog_clk);
    prog_we    = 1'b0;
    prog_rst_n = 1'b0;
    preload    = 1'b1;
    #1;
    check({tag, " reset outs"},
          int'({chain_we, chain_din, prog_we_o, prog_dout, prog_done, prog_err}), 0);
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    preload    = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit do_rst,
                           input logic [7:0] magic, input int unsigned len,
                           input bit pay[$], input logic [7:0] trl,
                           input int gap, input int exp_done,
                           input int exp_err, input int exp_pulses);
    bit bits[$];
    bit rb_exp[$];
    logic [15:0] pre;
    int first_pay;
    int diffs;
    logic [23:0] l24;
    l24 = len[23:0];
    for (int i = 7; i >= 0; i--) bits.push_back(magic[i]);
    for (int i = 23; i >= 0; i--) bits.push_back(l24[i]);
    foreach (pay[i]) bits.push_back(pay[i]);
    for (int i = 7; i >= 0; i--) bits.push_back(trl[i]);
    if (do_rst) do_reset(tag);
    q_cw.delete();
    q_rb.delete();
    first_cw  = -1;
    last_cw   = -1;
    first_pay = -1;
    for (int i = 0; i < bits.size(); i++) begin
      if (gap > 0 && gap < 100 && $urandom_range(99) < gap) begin
        repeat ($urandom_range(1, 3)) tick(1'b0, 1'($urandom));
      end
      tick(1'b1, bits[i]);
      if (i == 32) begin
        first_pay = ncyc - 1;
        check({tag, " err after header"}, int'(s_err), int'(magic != 8'hA5));
      end
      if (i == bits.size() - 1) check({tag, " done early"}, int'(s_done), 0);
      if (gap == 100) tick(1'b0, 1'($urandom));
    end
    tick(1'b0, 1'b0);
    check({tag, " done"}, int'(s_done), exp_done);
    check({tag, " err"}, int'(s_err), exp_err);
    repeat (8) tick(1'b1, 1'($urandom));
    repeat (3) tick(1'b0, 1'b0);
    check({tag, " sticky"}, int'({s_done, s_err}), int'({1'(exp_done), 1'(exp_err)}));
    check({tag, " pulses"}, q_cw.size(), exp_pulses);
    if (exp_pulses > 0 && q_cw.size() == exp_pulses) begin
      diffs = 0;
      foreach (q_cw[i]) if (q_cw[i] != pay[i]) diffs++;
      check({tag, " chain_din"}, diffs, 0);
    end
    pre = 16'hBEEF;
    for (int i = 15; i >= 0; i--) rb_exp.push_back(pre[i]);
    foreach (pay[i]) rb_exp.push_back(pay[i]);
    check({tag, " rb count"}, q_rb.size(), exp_pulses);
    if (q_rb.size() == exp_pulses) begin
      diffs = 0;
      foreach (q_rb[i]) if (q_rb[i] != rb_exp[i]) diffs++;
      check({tag, " rb data"}, diffs, 0);
    end
    if (gap == 0 && exp_pulses > 0) begin
      check({tag, " cw start"}, first_cw, first_pay + 1);
      check({tag, " cw span"}, last_cw - first_cw + 1, exp_pulses);
    end
  endtask

  function automatic void to_bits(input logic [63:0] v, input int unsigned len,
                                  output bit q[$]);
    q.delete();
    for (int i = int'(len) - 1; i >= 0; i--) q.push_back(v[i]);
  endfunction

  initial begin
    vec_t vt[7];
    bit pay[$];
    logic [7:0] trl;
    prog_rst_n = 1'b0;
    prog_we    = 1'b0;
    prog_din   = 1'b0;
    preload    = 1'b1;
    repeat (2) @(negedge prog_clk);
    prog_rst_n = 1'b1;
    preload    = 1'b0;

    vt[0] = '{8'hA5, 8,  64'h01,   8'h07, 0,   1, 0, 8};
    vt[1] = '{8'hA5, 8,  64'h01,   8'h06, 0,   0, 1, 8};
    vt[2] = '{8'h5A, 8,  64'h01,   8'h07, 0,   0, 1, 0};
    vt[3] = '{8'hA5, 0,  64'h00,   8'h00, 0,   1, 0, 0};
    vt[4] = '{8'hA5, 8,  64'h01,   8'h07, 100, 1, 0, 8};
    vt[5] = '{8'hA5, 16, 64'hC3A5, -1,    0,   1, 0, 16};
    vt[6] = '{8'hA5, 16, 64'h5A0F, -1,    40,  1, 0, 16};

    for (int k = 0; k < 7; k++) begin
      to_bits(vt[k].pay, vt[k].len, pay);
      trl = (vt[k].trl < 0) ? ref_crc(pay) : vt[k].trl[7:0];
      run_frame($sformatf("vec%0d", k), 1'b1, vt[k].magic, vt[k].len, pay,
                trl, vt[k].gap, vt[k].exp_done, vt[k].exp_err,
                vt[k].exp_pulses);
    end

    for (int k = 0; k < 12; k++) begin
      int unsigned len;
      bit bad_magic, corrupt;
      logic [7:0] magic;
      len       = $urandom_range(0, 40);
      bad_magic = ($urandom_range(7) == 0);
      corrupt   = ($urandom_range(3) == 0);
      magic     = bad_magic ? (8'hA5 ^ (8'h01 << $urandom_range(7))) : 8'hA5;
      to_bits({$urandom, $urandom}, len, pay);
      trl = ref_crc(pay);
      if (corrupt) trl = trl ^ 8'($urandom_range(1, 255));
      run_frame($sformatf("rnd%0d", k), 1'b1, magic, len, pay, trl,
                ($urandom_range(1) == 1) ? 30 : 0,
                int'(!bad_magic && !corrupt), int'(bad_magic || corrupt),
                bad_magic ? 0 : int'(len));
    end

    // Maximum length: must stay in payload, no counter wrap into CRC.
    begin
      logic [31:0] hdr;
      do_reset("maxlen");
      q_cw.delete();
      q_rb.delete();
      first_cw = -1;
      hdr = 32'hA5FF_FFFF;
      for (int i = 31; i >= 0; i--) tick(1'b1, hdr[i]);
      repeat (40) tick(1'b1, 1'($urandom));
      repeat (2) tick(1'b0, 1'b0);
      check("maxlen pulses", q_cw.size(), 40);
      check("maxlen flags", int'({s_done, s_err}), 0);
    end

    // Reset mid-payload, then a fresh frame without further reset.
    begin
      logic [31:0] hdr;
      do_reset("midrst");
      hdr = 32'hA500_0010;
      for (int i = 31; i >= 0; i--) tick(1'b1, hdr[i]);
      repeat (5) tick(1'b1, 1'b1);
      @(negedge prog_clk);
      check("midrst cw before", int'(chain_we), 1);
      prog_we    = 1'b0;
      prog_rst_n = 1'b0;
      preload    = 1'b1;
      #1;
      check("midrst outs", int'({chain_we, chain_din, prog_we_o, prog_dout,
                                 prog_done, prog_err}), 0);
      @(negedge prog_clk);
      prog_rst_n = 1'b1;
      preload    = 1'b0;
      to_bits(64'h9E37, 16, pay);
      run_frame("after_rst", 1'b0, 8'hA5, 16, pay, ref_crc(pay), 0, 1, 0, 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/prga_prog_receiver.md
Name: prga_prog_receiver

Overview:
- Fabric-side endpoint of the serial programming interface (prog_we / prog_din in, prog_dout / prog_we_o out).
- Receives a framed serial bitstream: header, payload, CRC trailer.
- Forwards payload bits into the configuration scan chain, checks the CRC, and raises prog_done or prog_err.
- Echoes the chain tail back on prog_dout / prog_we_o so the bitstream loader can read back the chain.

Parameters:
MAGIC, 8'hA5, required header magic byte.
LEN_W, 24, width of the payload-length field in the header.
CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1), init 8'h00, no reflection, no final XOR.

Ports:
prog_clk  input  1  programming clock; all state updates on its rising edge
prog_rst_n  input  1  asynchronous active-low reset
prog_we  input  1  serial bit valid; one bit consumed per cycle while high
prog_din  input  1  serial data, MSB first
chain_we  output  1  scan-chain shift enable
chain_din  output  1  scan-chain head data
chain_dout  input  1  scan-chain tail data
prog_we_o  output  1  readback valid (chain_we delayed by 1 cycle)
prog_dout  output  1  readback data (chain_dout sampled when chain_we=1)
prog_done  output  1  sticky: frame received and CRC matched
prog_err  output  1  sticky: bad magic or CRC mismatch

Behaviour:
- Reset (prog_rst_n=0, asynchronous):
  - state=HEADER; all outputs 0; bit counter, shift register and CRC cleared to 0.
- Frame layout (MSB first):
  - 8-bit magic, then LEN_W-bit length L (count of payload bits).
  - L payload bits.
  - 8-bit CRC over the payload bits only.
- A bit is consumed only in a cycle with prog_we=1. prog_we=0 cycles stall every state with no side effects; gaps of any length are legal.
- HEADER:
  - Shift prog_din into the header register; count 8+LEN_W bits.
  - On the last header bit:
    - magic != MAGIC -> ERROR.
    - else L==0 -> CRC.
    - else -> PAYLOAD, with the remaining counter = L.
- PAYLOAD, per consumed bit:
  - chain_we <= 1 and chain_din <= prog_din (registered, 1-cycle latency). chain_we <= 0 in every cycle without a consumed payload bit.
  - CRC update: fb = crc[7]^prog_din; crc <= {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - Decrement the counter; on the bit that takes it to 0 -> CRC.
- CRC:
  - Shift 8 trailer bits into a separate register.
  - On the 8th bit: trailer == computed crc -> DONE, else -> ERROR.
- DONE: prog_done=1 (registered, asserted the cycle after the last trailer bit). Sticky; further prog_we is ignored.
- ERROR: prog_err=1, same timing. Sticky.
- prog_done and prog_err are never both 1. Only reset leaves DONE or ERROR.
- Readback path:
  - prog_we_o <= chain_we.
  - prog_dout <= chain_we ? chain_dout : 0.
  - Active in all states, so the final chain shift is still echoed after DONE.
- Boundaries:
  - L = 2^LEN_W-1 must work with no counter wrap.
  - prog_we held continuously gives one bit per cycle with no bubbles at state transitions.
  - The header's last bit and the first payload bit may arrive on consecutive cycles.
- Reset asserted mid-frame aborts immediately: chain_we drops to 0 asynchronously and the next frame starts from HEADER.
- chain_we is never asserted for header or trailer bits.

Test Plan:
- Header A5_000008, payload 8'h01, trailer 8'h07, prog_we continuous:
  - chain_we high for exactly 8 cycles, starting 1 cycle after the first payload bit; chain_din = 0,0,0,0,0,0,0,1.
  - prog_done=1 one cycle after the last trailer bit; prog_err=0.
- Same frame with trailer 8'h06 -> prog_err=1, prog_done=0, chain_we still pulsed 8 times.
- Header magic 8'h5A -> prog_err=1 one cycle after the 32nd bit; chain_we never asserted; a later trailer is ignored.
- Header A5_000000, trailer 8'h00 -> prog_done=1 with zero chain_we pulses.
- Frame 1 with prog_we toggling 1/0 every cycle:
  - Same chain_din sequence and prog_done result as the continuous case.
  - Bit count correct across stalls.
- Chain modelled as a 16-bit shift register preloaded with 16'hBEEF, frame with L=16:
  - prog_we_o pulses 16 times; prog_dout = 1,0,1,1,1,1,1,0,1,1,1,0,1,1,1,1 (MSB first).
  - prog_rst_n pulsed low after payload bit 5 -> all outputs 0 immediately; a fresh full frame then completes with prog_done=1.
